// File: rtl/call_return_stack.sv
// Return-address stack for the CALL/RET decode path: pushes on CALL and serves the
// top entry as a same-cycle jump target on RET. Overflow, underflow and protocol errors are sticky.
module call_return_stack #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  call,
    input  logic                  ret,
    input  logic [ADDR_WIDTH-1:0] return_address,
    input  logic                  clear_err,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_target,
    output logic [CNT_WIDTH-1:0]  depth,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  proto_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_WIDTH-1:0]  sp_q, sp_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  proto_err_q, proto_err_d;

    logic                  is_full, is_empty;
    logic                  do_push, do_pop;
    logic                  set_ovf, set_unf, set_proto;
    logic [IDX_W-1:0]      wr_idx, top_idx;

    assign is_full   = (sp_q == CNT_WIDTH'(DEPTH));
    assign is_empty  = (sp_q == '0);
    assign do_push   = call & ~ret & ~is_full;
    assign do_pop    = ret & ~call & ~is_empty;
    assign set_ovf   = call & ~ret & is_full;
    assign set_unf   = ret & ~call & is_empty;
    assign set_proto = call & ret;

    // sp never exceeds DEPTH-1 when a push is allowed, so truncation is safe.
    assign wr_idx  = IDX_W'(sp_q);
    assign top_idx = IDX_W'(sp_q - CNT_WIDTH'(1));

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + CNT_WIDTH'(1);
        end else if (do_pop) begin
            sp_d = sp_q - CNT_WIDTH'(1);
        end
        // A new set condition overrides a clear in the same cycle.
        overflow_d  = (overflow_q  & ~clear_err) | set_ovf;
        underflow_d = (underflow_q & ~clear_err) | set_unf;
        proto_err_d = (proto_err_q & ~clear_err) | set_proto;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage is not reset; entries above sp are never observed.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_idx] <= return_address;
        end
    end

    assign pc_load   = do_pop;
    assign pc_target = is_empty ? '0 : mem_q[top_idx];
    assign depth     = sp_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_call_return_stack.sv
// Directed vector bench for call_return_stack: each row drives one cycle of inputs and
// checks the outputs seen during that cycle, before the edge that applies them.
module tb_call_return_stack;
    logic       clk = 1'b0;
    logic       rst, call, ret, clear_err;
    logic [7:0] return_address;
    logic       pc_load, full, empty, overflow, underflow, proto_err;
    logic [7:0] pc_target;
    logic [4:0] depth;

    int n_checks = 0;
    int n_pass   = 0;

    call_return_stack #(.DEPTH(16), .ADDR_WIDTH(8), .CNT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .call(call), .ret(ret),
        .return_address(return_address), .clear_err(clear_err),
        .pc_load(pc_load), .pc_target(pc_target), .depth(depth),
        .full(full), .empty(empty), .overflow(overflow),
        .underflow(underflow), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, c, t, clr;
        logic [7:0]  a;
        logic [18:0] exp;
    } vec_t;

    vec_t vq[$];

    // Packed order: pc_load, pc_target, depth, full, empty, overflow, underflow, proto_err
    function automatic logic [18:0] ex(input logic pl, input logic [7:0] pt, input logic [4:0] d,
                                       input logic f, input logic e, input logic o,
                                       input logic u, input logic p);
        return {pl, pt, d, f, e, o, u, p};
    endfunction

    function automatic void add(input logic r, input logic c, input logic t, input logic [7:0] a,
                                input logic clr, input logic [18:0] e);
        vec_t v;
        v.r = r; v.c = c; v.t = t; v.a = a; v.clr = clr; v.exp = e;
        vq.push_back(v);
    endfunction

    task automatic apply(input logic r, input logic c, input logic t, input logic [7:0] a,
                         input logic clr, input logic [18:0] e, input string name);
        logic [18:0] act;
        @(negedge clk);
        rst = r; call = c; ret = t; return_address = a; clear_err = clr;
        #1;
        act = {pc_load, pc_target, depth, full, empty, overflow, underflow, proto_err};
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got pl=%0b pt=%02h d=%0d f=%0b e=%0b o=%0b u=%0b p=%0b, expected pl=%0b pt=%02h d=%0d f=%0b e=%0b o=%0b u=%0b p=%0b",
                      name, act[18], act[17:10], act[9:5], act[4], act[3], act[2], act[1], act[0],
                      e[18], e[17:10], e[9:5], e[4], e[3], e[2], e[1], e[0]);
    endtask

    initial begin
        rst = 1'b1; call = 1'b0; ret = 1'b0; return_address = '0; clear_err = 1'b0;
        repeat (2) @(posedge clk);

        // reset, then idle
        for (int i = 0; i < 3; i++) add(0,0,0,8'h00,0, ex(0,8'h00,0,0,1,0,0,0));
        // three pushes, three pops
        add(0,1,0,8'h08,0, ex(0,8'h00,0,0,1,0,0,0));
        add(0,1,0,8'h14,0, ex(0,8'h08,1,0,0,0,0,0));
        add(0,1,0,8'h2C,0, ex(0,8'h14,2,0,0,0,0,0));
        add(0,0,1,8'h00,0, ex(1,8'h2C,3,0,0,0,0,0));
        add(0,0,1,8'h00,0, ex(1,8'h14,2,0,0,0,0,0));
        add(0,0,1,8'h00,0, ex(1,8'h08,1,0,0,0,0,0));
        add(0,0,0,8'h00,0, ex(0,8'h00,0,0,1,0,0,0));
        // underflow and recovery
        add(0,0,1,8'h00,0, ex(0,8'h00,0,0,1,0,0,0));
        add(0,0,0,8'h00,0, ex(0,8'h00,0,0,1,0,1,0));
        add(0,0,0,8'h00,1, ex(0,8'h00,0,0,1,0,1,0));
        add(0,1,0,8'h40,0, ex(0,8'h00,0,0,1,0,0,0));
        add(0,0,1,8'h00,0, ex(1,8'h40,1,0,0,0,0,0));
        add(0,0,0,8'h00,0, ex(0,8'h00,0,0,1,0,0,0));
        // fill to full, then overflow
        for (int i = 0; i < 16; i++)
            add(0,1,0,8'(8'h10 + i),0, ex(0,(i == 0) ? 8'h00 : 8'(8'h0F + i),5'(i),0,(i == 0),0,0,0));
        add(0,1,0,8'hAA,0, ex(0,8'h1F,16,1,0,0,0,0));
        add(0,0,0,8'h00,0, ex(0,8'h1F,16,1,0,1,0,0));
        add(0,0,1,8'h00,0, ex(1,8'h1F,16,1,0,1,0,0));
        add(0,0,0,8'h00,0, ex(0,8'h1E,15,0,0,1,0,0));
        // reset clears depth and sticky overflow
        add(1,0,0,8'h00,0, ex(0,8'h1E,15,0,0,1,0,0));
        add(0,1,0,8'h30,0, ex(0,8'h00,0,0,1,0,0,0));
        // simultaneous call+ret, and set-beats-clear
        add(0,1,1,8'h55,0, ex(0,8'h30,1,0,0,0,0,0));
        add(0,0,0,8'h00,0, ex(0,8'h30,1,0,0,0,0,1));
        add(0,1,1,8'h66,1, ex(0,8'h30,1,0,0,0,0,1));
        add(0,0,0,8'h00,0, ex(0,8'h30,1,0,0,0,0,1));
        add(0,0,0,8'h00,1, ex(0,8'h30,1,0,0,0,0,1));
        add(0,0,0,8'h00,0, ex(0,8'h30,1,0,0,0,0,0));
        // reset in the same cycle as a ret
        add(1,0,0,8'h00,0, ex(0,8'h30,1,0,0,0,0,0));
        add(0,1,0,8'h04,0, ex(0,8'h00,0,0,1,0,0,0));
        add(0,1,0,8'h08,0, ex(0,8'h04,1,0,0,0,0,0));
        add(1,0,1,8'h00,0, ex(1,8'h08,2,0,0,0,0,0));
        add(0,0,0,8'h00,0, ex(0,8'h00,0,0,1,0,0,0));
        add(0,0,1,8'h00,0, ex(0,8'h00,0,0,1,0,0,0));
        add(0,0,0,8'h00,0, ex(0,8'h00,0,0,1,0,1,0));

        foreach (vq[i])
            apply(vq[i].r, vq[i].c, vq[i].t, vq[i].a, vq[i].clr, vq[i].exp, $sformatf("vec%0d", i));

        // back-to-back push/pop pairs on top of one resident entry
        apply(1,0,0,8'h00,0, ex(0,8'h00,0,0,1,0,1,0), "b2b_rst");
        apply(0,1,0,8'hC0,0, ex(0,8'h00,0,0,1,0,0,0), "b2b_base");
        for (int k = 0; k < 4; k++) begin
            logic [7:0] v;
            v = 8'(8'h81 + 8'(k * 8'h23));
            apply(0,1,0,v,0,     ex(0,8'hC0,1,0,0,0,0,0), $sformatf("b2b_push%0d", k));
            apply(0,0,1,8'h00,0, ex(1,v,2,0,0,0,0,0),     $sformatf("b2b_pop%0d", k));
        end
        apply(0,0,1,8'h00,0, ex(1,8'hC0,1,0,0,0,0,0), "b2b_last");
        apply(0,0,0,8'h00,0, ex(0,8'h00,0,0,1,0,0,0), "b2b_empty");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
